// File: rtl/fft_peak_search.sv
// FFT output peak search: per-frame max-power bin, mean power, overflow flag and detect.
// Define FFT_PEAK_ADAPTIVE_EN for a detect threshold relative to mean power (else fixed THRESH_PWR).
module fft_peak_search #(
  parameter int          POINTS       = 256,
  parameter int          DATA_BITS    = 32,
  parameter int          THRESH_SHIFT = 3,
  parameter logic [31:0] THRESH_PWR   = 32'h0010_0000
) (
  input  logic                       CLK,
  input  logic                       NGRST,
  input  logic                       CLEAR,
  input  logic [DATA_BITS-1:0]       DATAI_RE,
  input  logic [DATA_BITS-1:0]       DATAI_IM,
  input  logic                       DATAI_VALID,
  input  logic                       OVFLOW_IN,
  output logic                       BUSY,
  output logic                       PEAK_VALID,
  output logic [$clog2(POINTS)-1:0]  PEAK_BIN,
  output logic [31:0]                PEAK_PWR,
  output logic [31:0]                MEAN_PWR,
  output logic                       PEAK_OVF,
  output logic                       DETECT
);

  localparam int BIN_W = $clog2(POINTS);
  localparam int SUM_W = 32 + BIN_W;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(POINTS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             r_state;
  logic               r_busy;
  logic [BIN_W-1:0]   r_bin_cnt;
  logic               r_s1_vld, r_s1_ovf, r_s2_vld, r_s2_ovf;
  logic [BIN_W-1:0]   r_s1_bin, r_s2_bin;
  logic [31:0]        r_s1_sq_re, r_s1_sq_im, r_s2_pwr;
  logic [31:0]        r_max;
  logic [BIN_W-1:0]   r_max_bin;
  logic               r_ovf;
  logic               r_peak_valid, r_peak_ovf, r_detect;
  logic [BIN_W-1:0]   r_peak_bin;
  logic [31:0]        r_peak_pwr;

  logic signed [15:0] w_re16, w_im16;
  logic signed [31:0] w_sq_re, w_sq_im;
  logic               w_accum_nxt, w_s1_vld_nxt, w_s2_vld_nxt;
  logic               w_first;
  logic [31:0]        w_max_nxt;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic               w_ovf_nxt, w_detect_nxt;

  // Only the top 16 bits of each component contribute; |x| <= 2^15 keeps re^2+im^2 <= 2^31.
  assign w_re16  = DATAI_RE[DATA_BITS-1 -: 16];
  assign w_im16  = DATAI_IM[DATA_BITS-1 -: 16];
  assign w_sq_re = 32'(w_re16) * 32'(w_re16);
  assign w_sq_im = 32'(w_im16) * 32'(w_im16);

  assign w_s1_vld_nxt = DATAI_VALID & ~CLEAR;
  assign w_s2_vld_nxt = r_s1_vld & ~CLEAR;
  assign w_accum_nxt  = ~CLEAR & (DATAI_VALID ? (r_bin_cnt != LAST_BIN) : (r_state == ACCUM));

  // NOTE: every clocked block uses non-blocking (<=) so all flops sample pre-edge values.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_bin_cnt <= '0;
    end else begin
      r_state <= w_accum_nxt ? ACCUM : IDLE;
      r_busy  <= w_accum_nxt | w_s1_vld_nxt | w_s2_vld_nxt;
      if (CLEAR)            r_bin_cnt <= '0;
      else if (DATAI_VALID) r_bin_cnt <= r_bin_cnt + BIN_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      r_s1_vld   <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_bin   <= '0;
      r_s1_sq_re <= '0;
      r_s1_sq_im <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_bin   <= '0;
      r_s2_pwr   <= '0;
    end else begin
      r_s1_vld   <= w_s1_vld_nxt;
      r_s1_ovf   <= OVFLOW_IN;
      r_s1_bin   <= r_bin_cnt;
      r_s1_sq_re <= $unsigned(w_sq_re);
      r_s1_sq_im <= $unsigned(w_sq_im);
      r_s2_vld   <= w_s2_vld_nxt;
      r_s2_ovf   <= r_s1_ovf;
      r_s2_bin   <= r_s1_bin;
      r_s2_pwr   <= r_s1_sq_re + r_s1_sq_im;
    end
  end

  // A bin-0 tag restarts the statistics, so back-to-back frames need no gap.
  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_first   = (r_s2_bin == '0);
    w_max_nxt = r_max;
    w_bin_nxt = r_max_bin;
    if (w_first || (r_s2_pwr > r_max)) begin
      w_max_nxt = r_s2_pwr;
      w_bin_nxt = r_s2_bin;
    end
    w_ovf_nxt = r_s2_ovf | (~w_first & r_ovf);
  end

`ifdef FFT_PEAK_ADAPTIVE_EN
  logic [SUM_W-1:0] r_sum, w_sum_nxt;
  logic [31:0]      r_mean_pwr, w_mean_nxt;
  logic             w_unused_cfg;

  assign w_sum_nxt    = (w_first ? '0 : r_sum) + SUM_W'(r_s2_pwr);
  assign w_mean_nxt   = w_sum_nxt[SUM_W-1:BIN_W];
  assign w_detect_nxt = 40'(w_max_nxt) > (40'(w_mean_nxt) << THRESH_SHIFT);
  assign MEAN_PWR     = r_mean_pwr;
  assign w_unused_cfg = ^{THRESH_PWR, w_sum_nxt[BIN_W-1:0]};

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      r_sum      <= '0;
      r_mean_pwr <= '0;
    end else if (r_s2_vld && !CLEAR) begin
      r_sum <= w_sum_nxt;
      if (r_s2_bin == LAST_BIN) r_mean_pwr <= w_mean_nxt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_detect_nxt = w_max_nxt > THRESH_PWR;
  assign MEAN_PWR     = '0;
  assign w_unused_cfg = ^THRESH_SHIFT;
`endif

  if (DATA_BITS > 16) begin : g_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^{DATAI_RE[DATA_BITS-17:0], DATAI_IM[DATA_BITS-17:0]};
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      r_max        <= '0;
      r_max_bin    <= '0;
      r_ovf        <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_pwr   <= '0;
      r_peak_ovf   <= 1'b0;
      r_detect     <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (r_s2_vld && !CLEAR) begin
        r_max     <= w_max_nxt;
        r_max_bin <= w_bin_nxt;
        r_ovf     <= w_ovf_nxt;
        if (r_s2_bin == LAST_BIN) begin
          r_peak_valid <= 1'b1;
          r_peak_bin   <= w_bin_nxt;
          r_peak_pwr   <= w_max_nxt;
          r_peak_ovf   <= w_ovf_nxt;
          r_detect     <= w_detect_nxt;
        end
      end
    end
  end

  assign BUSY       = r_busy;
  assign PEAK_VALID = r_peak_valid;
  assign PEAK_BIN   = r_peak_bin;
  assign PEAK_PWR   = r_peak_pwr;
  assign PEAK_OVF   = r_peak_ovf;
  assign DETECT     = r_detect;

endmodule

// File: tb/tb_fft_peak_search.sv
// Directed self-checking bench for fft_peak_search (expectations follow FFT_PEAK_ADAPTIVE_EN).
module tb_fft_peak_search;

  localparam int POINTS = 256;
`ifdef FFT_PEAK_ADAPTIVE_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        NGRST = 1'b1;
  logic        CLEAR = 1'b0;
  logic [31:0] DATAI_RE = '0, DATAI_IM = '0;
  logic        DATAI_VALID = 1'b0;
  logic        OVFLOW_IN = 1'b0;
  logic        BUSY, PEAK_VALID, PEAK_OVF, DETECT;
  logic [7:0]  PEAK_BIN;
  logic [31:0] PEAK_PWR, MEAN_PWR;

  fft_peak_search dut (
    .CLK(CLK), .NGRST(NGRST), .CLEAR(CLEAR),
    .DATAI_RE(DATAI_RE), .DATAI_IM(DATAI_IM), .DATAI_VALID(DATAI_VALID),
    .OVFLOW_IN(OVFLOW_IN), .BUSY(BUSY), .PEAK_VALID(PEAK_VALID),
    .PEAK_BIN(PEAK_BIN), .PEAK_PWR(PEAK_PWR), .MEAN_PWR(MEAN_PWR),
    .PEAK_OVF(PEAK_OVF), .DETECT(DETECT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int strobes = 0;

  int          cap_cyc  [16];
  logic [7:0]  cap_bin  [16];
  logic [31:0] cap_pwr  [16];
  logic [31:0] cap_mean [16];
  logic        cap_ovf  [16];
  logic        cap_det  [16];
  logic        cap_busy [16];

  logic [31:0] fr_re  [POINTS];
  logic [31:0] fr_im  [POINTS];
  logic        fr_ovf [POINTS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (PEAK_VALID === 1'b1) begin
      cap_cyc[strobes % 16]  = cyc;
      cap_bin[strobes % 16]  = PEAK_BIN;
      cap_pwr[strobes % 16]  = PEAK_PWR;
      cap_mean[strobes % 16] = MEAN_PWR;
      cap_ovf[strobes % 16]  = PEAK_OVF;
      cap_det[strobes % 16]  = DETECT;
      cap_busy[strobes % 16] = BUSY;
      strobes++;
    end
  end

  task automatic zero_frame();
    for (int b = 0; b < POINTS; b++) begin
      fr_re[b]  = '0;
      fr_im[b]  = '0;
      fr_ovf[b] = 1'b0;
    end
  endtask

  // Drives bins first..last on consecutive cycles, optionally stalling gap_len cycles before gap_at.
  task automatic send_bins(input int first, input int last, input int gap_at, input int gap_len);
    for (int b = first; b <= last; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge CLK);
          DATAI_VALID = 1'b0;
          OVFLOW_IN   = 1'b0;
        end
      end
      @(negedge CLK);
      DATAI_VALID = 1'b1;
      DATAI_RE    = fr_re[b];
      DATAI_IM    = fr_im[b];
      OVFLOW_IN   = fr_ovf[b];
      last_cyc    = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      DATAI_VALID = 1'b0;
      OVFLOW_IN   = 1'b0;
      CLEAR       = 1'b0;
      #1;
    end
  endtask

  task automatic wait_strobes(input int target, input string tag);
    int n;
    n = 0;
    while (strobes < target && n < 40) begin
      idle(1);
      n++;
    end
    check(tag, strobes, target);
  endtask

  initial begin
    int base;
    int idx;

    #1 NGRST = 1'b0;
    idle(3);
    check("rst_valid", PEAK_VALID, 0);
    check("rst_bin",   PEAK_BIN,   0);
    check("rst_pwr",   PEAK_PWR,   0);
    check("rst_busy",  BUSY,       0);
    @(negedge CLK);
    NGRST = 1'b1;
    idle(2);

    // Single tone at bin 37.
    zero_frame();
    fr_re[37] = 32'h0100_0000;
    base = strobes;
    send_bins(0, 127, -1, 0);
    #1 check("t1_busy_mid", BUSY, 1);
    send_bins(128, 255, -1, 0);
    wait_strobes(base + 1, "t1_strobe");
    idx = base % 16;
    check("t1_latency", cap_cyc[idx] - last_cyc, 3);
    check("t1_bin",     cap_bin[idx],  37);
    check("t1_pwr",     cap_pwr[idx],  65536);
    check("t1_mean",    cap_mean[idx], ADAPT ? 256 : 0);
    check("t1_det",     cap_det[idx],  ADAPT ? 1 : 0);
    check("t1_ovf",     cap_ovf[idx],  0);
    check("t1_busy_end", cap_busy[idx], 0);

    // Equal power on bins 10 and 200, with a mid-frame stall.
    zero_frame();
    fr_re[10]  = 32'h0001_0000;
    fr_re[200] = 32'h0001_0000;
    base = strobes;
    send_bins(0, 255, 50, 5);
    wait_strobes(base + 1, "t2_strobe");
    idx = base % 16;
    check("t2_latency", cap_cyc[idx] - last_cyc, 3);
    check("t2_bin",     cap_bin[idx], 10);
    check("t2_pwr",     cap_pwr[idx], 1);
    check("t2_det",     cap_det[idx], ADAPT ? 1 : 0);

    // Back-to-back frames: stronger peak at bin 5, then weaker peak at bin 250.
    zero_frame();
    fr_re[5] = 32'h0200_0000;
    base = strobes;
    send_bins(0, 255, -1, 0);
    zero_frame();
    fr_re[250] = 32'h0100_0000;
    send_bins(0, 255, -1, 0);
    wait_strobes(base + 2, "t3_strobes");
    idx = base % 16;
    check("t3_spacing", cap_cyc[(base + 1) % 16] - cap_cyc[idx], 256);
    check("t3_bin_a",   cap_bin[idx], 5);
    check("t3_pwr_a",   cap_pwr[idx], 262144);
    check("t3_bin_b",   cap_bin[(base + 1) % 16], 250);
    check("t3_pwr_b",   cap_pwr[(base + 1) % 16], 65536);
    check("t3_mean_b",  cap_mean[(base + 1) % 16], ADAPT ? 256 : 0);

    // CLEAR at bin 100 drops the partial frame and the coinciding sample.
    zero_frame();
    fr_re[20] = 32'h0400_0000;
    base = strobes;
    send_bins(0, 99, -1, 0);
    @(negedge CLK);
    CLEAR       = 1'b1;
    DATAI_VALID = 1'b1;
    DATAI_RE    = 32'h7fff_0000;
    idle(6);
    check("t4_no_strobe", strobes, base);
    check("t4_held_bin",  PEAK_BIN, 250);
    check("t4_busy",      BUSY, 0);
    zero_frame();
    fr_re[77] = 32'h0100_0000;
    fr_im[77] = 32'h0100_0000;
    send_bins(0, 255, -1, 0);
    wait_strobes(base + 1, "t4_strobe");
    idle(5);
    check("t4_one_strobe", strobes, base + 1);
    idx = base % 16;
    check("t4_latency", cap_cyc[idx] - last_cyc, 3);
    check("t4_bin",     cap_bin[idx], 77);
    check("t4_pwr",     cap_pwr[idx], 131072);
    check("t4_mean",    cap_mean[idx], ADAPT ? 512 : 0);

    // Full-scale negative on every bin, overflow flagged at bin 3.
    for (int b = 0; b < POINTS; b++) begin
      fr_re[b]  = 32'h8000_0000;
      fr_im[b]  = 32'h8000_0000;
      fr_ovf[b] = (b == 3);
    end
    base = strobes;
    send_bins(0, 255, -1, 0);
    wait_strobes(base + 1, "t5_strobe");
    idx = base % 16;
    check("t5_bin",  cap_bin[idx], 0);
    check("t5_pwr",  cap_pwr[idx], 32'h8000_0000);
    check("t5_ovf",  cap_ovf[idx], 1);
    check("t5_mean", cap_mean[idx], ADAPT ? 32'h8000_0000 : 0);
    check("t5_det",  cap_det[idx], ADAPT ? 0 : 1);

    // Reset mid-frame clears outputs at once; the next frame starts at bin 0.
    zero_frame();
    fr_re[60] = 32'h0400_0000;
    base = strobes;
    send_bins(0, 127, -1, 0);
    #2;
    NGRST       = 1'b0;
    DATAI_VALID = 1'b0;
    #1;
    check("t6_rst_pwr",  PEAK_PWR, 0);
    check("t6_rst_ovf",  PEAK_OVF, 0);
    check("t6_rst_busy", BUSY, 0);
    idle(2);
    @(negedge CLK);
    NGRST = 1'b1;
    idle(5);
    check("t6_no_strobe", strobes, base);
    zero_frame();
    fr_re[200] = 32'h0100_0000;
    fr_im[200] = 32'hff00_0000;
    send_bins(0, 255, -1, 0);
    wait_strobes(base + 1, "t6_strobe");
    idx = base % 16;
    check("t6_latency", cap_cyc[idx] - last_cyc, 3);
    check("t6_bin",     cap_bin[idx], 200);
    check("t6_pwr",     cap_pwr[idx], 131072);
    check("t6_ovf",     cap_ovf[idx], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
